// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 32-bit ALU path: captures decoded operands and control,
// supports stall/flush, and forwards MEM/WB results onto the ALU operands combinationally.
module id_ex_stage #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_e,
    input  logic                  flush_e,
    input  logic                  valid_d,
    input  logic [DATA_W-1:0]     rd1_d,
    input  logic [DATA_W-1:0]     rd2_d,
    input  logic [DATA_W-1:0]     imm_d,
    input  logic [REG_ADDR_W-1:0] rs_d,
    input  logic [REG_ADDR_W-1:0] rt_d,
    input  logic [REG_ADDR_W-1:0] rd_d,
    input  logic [2:0]            alu_control_d,
    input  logic                  alu_src_d,
    input  logic                  reg_dst_d,
    input  logic                  reg_write_d,
    input  logic                  mem_to_reg_d,
    input  logic                  mem_write_d,
    input  logic [DATA_W-1:0]     alu_out_m,
    input  logic [DATA_W-1:0]     result_w,
    input  logic [REG_ADDR_W-1:0] write_reg_m,
    input  logic [REG_ADDR_W-1:0] write_reg_w,
    input  logic                  reg_write_m,
    input  logic                  reg_write_w,
    output logic [DATA_W-1:0]     num1_e,
    output logic [DATA_W-1:0]     num2_e,
    output logic [2:0]            alu_control_e,
    output logic [DATA_W-1:0]     write_data_e,
    output logic [REG_ADDR_W-1:0] write_reg_e,
    output logic                  reg_write_e,
    output logic                  mem_to_reg_e,
    output logic                  mem_write_e,
    output logic [REG_ADDR_W-1:0] rs_e,
    output logic [REG_ADDR_W-1:0] rt_e,
    output logic                  valid_e,
    output logic [1:0]            fwd_a_e,
    output logic [1:0]            fwd_b_e
);

    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [1:0] FwdNone = 2'b00;
    localparam logic [1:0] FwdWb   = 2'b01;
    localparam logic [1:0] FwdMem  = 2'b10;

    logic                  valid_q;
    logic [DATA_W-1:0]     rd1_q;
    logic [DATA_W-1:0]     rd2_q;
    logic [DATA_W-1:0]     imm_q;
    logic [REG_ADDR_W-1:0] rs_q;
    logic [REG_ADDR_W-1:0] rt_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [2:0]            alu_control_q;
    logic                  alu_src_q;
    logic                  reg_dst_q;
    logic                  reg_write_q;
    logic                  mem_to_reg_q;
    logic                  mem_write_q;

    // Priority: reset, then bubble, then hold, then capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= 1'b0;
            rd1_q         <= '0;
            rd2_q         <= '0;
            imm_q         <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            rd_q          <= '0;
            alu_control_q <= '0;
            alu_src_q     <= 1'b0;
            reg_dst_q     <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            mem_write_q   <= 1'b0;
        end else if (flush_e) begin
            valid_q       <= 1'b0;
            rd1_q         <= '0;
            rd2_q         <= '0;
            imm_q         <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            rd_q          <= '0;
            alu_control_q <= AluAdd;
            alu_src_q     <= 1'b0;
            reg_dst_q     <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            mem_write_q   <= 1'b0;
        end else if (!stall_e) begin
            valid_q       <= valid_d;
            rd1_q         <= rd1_d;
            rd2_q         <= rd2_d;
            imm_q         <= imm_d;
            rs_q          <= rs_d;
            rt_q          <= rt_d;
            rd_q          <= rd_d;
            alu_control_q <= alu_control_d;
            alu_src_q     <= alu_src_d;
            reg_dst_q     <= reg_dst_d;
            reg_write_q   <= reg_write_d;
            mem_to_reg_q  <= mem_to_reg_d;
            mem_write_q   <= mem_write_d;
        end
    end

    // MEM is the younger producer, so it wins over WB; r0 is hardwired zero.
    always_comb begin
        fwd_a_e = FwdNone;
        if (reg_write_m && (write_reg_m != '0) && (write_reg_m == rs_q)) begin
            fwd_a_e = FwdMem;
        end else if (reg_write_w && (write_reg_w != '0) && (write_reg_w == rs_q)) begin
            fwd_a_e = FwdWb;
        end

        fwd_b_e = FwdNone;
        if (reg_write_m && (write_reg_m != '0) && (write_reg_m == rt_q)) begin
            fwd_b_e = FwdMem;
        end else if (reg_write_w && (write_reg_w != '0) && (write_reg_w == rt_q)) begin
            fwd_b_e = FwdWb;
        end
    end

    always_comb begin
        num1_e = rd1_q;
        unique case (fwd_a_e)
            FwdMem:  num1_e = alu_out_m;
            FwdWb:   num1_e = result_w;
            default: num1_e = rd1_q;
        endcase

        write_data_e = rd2_q;
        unique case (fwd_b_e)
            FwdMem:  write_data_e = alu_out_m;
            FwdWb:   write_data_e = result_w;
            default: write_data_e = rd2_q;
        endcase

        num2_e = alu_src_q ? imm_q : write_data_e;
    end

    assign write_reg_e   = reg_dst_q ? rd_q : rt_q;
    assign alu_control_e = alu_control_q;
    assign reg_write_e   = reg_write_q;
    assign mem_to_reg_e  = mem_to_reg_q;
    assign mem_write_e   = mem_write_q;
    assign rs_e          = rs_q;
    assign rt_e          = rt_q;
    assign valid_e       = valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus queues hand-computed expectations, a negedge
// monitor pops each one and compares it against the E-stage outputs.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_e, flush_e, valid_d;
    logic [31:0] rd1_d, rd2_d, imm_d, alu_out_m, result_w;
    logic [4:0]  rs_d, rt_d, rd_d, write_reg_m, write_reg_w;
    logic [2:0]  alu_control_d;
    logic        alu_src_d, reg_dst_d, reg_write_d, mem_to_reg_d, mem_write_d;
    logic        reg_write_m, reg_write_w;

    logic [31:0] num1_e, num2_e, write_data_e;
    logic [2:0]  alu_control_e;
    logic [4:0]  write_reg_e, rs_e, rt_e;
    logic        reg_write_e, mem_to_reg_e, mem_write_e, valid_e;
    logic [1:0]  fwd_a_e, fwd_b_e;

    typedef struct packed {
        logic [31:0] num1;
        logic [31:0] num2;
        logic [31:0] wdata;
        logic [2:0]  aluc;
        logic [4:0]  wreg;
        logic        rw;
        logic        m2r;
        logic        mw;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        valid;
        logic [1:0]  fa;
        logic [1:0]  fb;
    } fields_t;

    typedef struct {
        string   name;
        fields_t f;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    id_ex_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e), .valid_d(valid_d),
        .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d), .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
        .alu_control_d(alu_control_d), .alu_src_d(alu_src_d), .reg_dst_d(reg_dst_d),
        .reg_write_d(reg_write_d), .mem_to_reg_d(mem_to_reg_d), .mem_write_d(mem_write_d),
        .alu_out_m(alu_out_m), .result_w(result_w), .write_reg_m(write_reg_m),
        .write_reg_w(write_reg_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .num1_e(num1_e), .num2_e(num2_e), .alu_control_e(alu_control_e),
        .write_data_e(write_data_e), .write_reg_e(write_reg_e), .reg_write_e(reg_write_e),
        .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e), .rs_e(rs_e), .rt_e(rt_e),
        .valid_e(valid_e), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(string name, logic [31:0] num1, logic [31:0] num2,
                                logic [31:0] wdata, logic [2:0] aluc, logic [4:0] wreg,
                                logic rw, logic m2r, logic mw, logic [4:0] rs, logic [4:0] rt,
                                logic valid, logic [1:0] fa, logic [1:0] fb);
        exp_t e;
        e.name = name;
        e.f = '{num1: num1, num2: num2, wdata: wdata, aluc: aluc, wreg: wreg, rw: rw,
                m2r: m2r, mw: mw, rs: rs, rt: rt, valid: valid, fa: fa, fb: fb};
        return e;
    endfunction

    // Monitor: outputs are sampled on the falling edge, away from the capture edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t    e;
            fields_t act;
            e = sb_q.pop_front();
            act = '{num1: num1_e, num2: num2_e, wdata: write_data_e, aluc: alu_control_e,
                    wreg: write_reg_e, rw: reg_write_e, m2r: mem_to_reg_e, mw: mem_write_e,
                    rs: rs_e, rt: rt_e, valid: valid_e, fa: fwd_a_e, fb: fwd_b_e};
            n_tests++;
            if (act !== e.f) begin
                n_fail++;
                $display("FAIL %s: got num1=%h num2=%h wd=%h op=%b wr=%0d rw/m2r/mw=%b%b%b rs=%0d rt=%0d v=%b fa=%b fb=%b | expected num1=%h num2=%h wd=%h op=%b wr=%0d rw/m2r/mw=%b%b%b rs=%0d rt=%0d v=%b fa=%b fb=%b",
                         e.name, act.num1, act.num2, act.wdata, act.aluc, act.wreg, act.rw,
                         act.m2r, act.mw, act.rs, act.rt, act.valid, act.fa, act.fb,
                         e.f.num1, e.f.num2, e.f.wdata, e.f.aluc, e.f.wreg, e.f.rw, e.f.m2r,
                         e.f.mw, e.f.rs, e.f.rt, e.f.valid, e.f.fa, e.f.fb);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(exp_t e);
        sb_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rst = 0; stall_e = 0; flush_e = 0; valid_d = 0;
        rd1_d = 0; rd2_d = 0; imm_d = 0; rs_d = 0; rt_d = 0; rd_d = 0;
        alu_control_d = 0; alu_src_d = 0; reg_dst_d = 0;
        reg_write_d = 0; mem_to_reg_d = 0; mem_write_d = 0;
        alu_out_m = 0; result_w = 0; write_reg_m = 0; write_reg_w = 0;
        reg_write_m = 0; reg_write_w = 0;
    endtask

    task automatic load_reload();
        clear_inputs();
        valid_d = 1; rs_d = 2; rt_d = 3; rd_d = 4; rd1_d = 32'h11; rd2_d = 32'h22;
        imm_d = 32'h33; alu_control_d = 3'b110; reg_write_d = 1; mem_to_reg_d = 1;
    endtask

    initial begin
        // Reset with every input nonzero, including stall and flush.
        rst = 1; stall_e = 1; flush_e = 1; valid_d = 1;
        rd1_d = 32'hAAAA_5555; rd2_d = 32'h1234_5678; imm_d = 32'hFFFF_0001;
        rs_d = 5'd4; rt_d = 5'd6; rd_d = 5'd9; alu_control_d = 3'b111;
        alu_src_d = 1; reg_dst_d = 1; reg_write_d = 1; mem_to_reg_d = 1; mem_write_d = 1;
        alu_out_m = 32'hDEAD_BEEF; result_w = 32'hCAFE_F00D;
        write_reg_m = 5'd4; write_reg_w = 5'd6; reg_write_m = 1; reg_write_w = 1;
        step(); step();
        expect_now(mk("reset", 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));

        clear_inputs();
        valid_d = 1; rd1_d = 5; rd2_d = 7; alu_control_d = 3'b010; reg_dst_d = 1;
        rd_d = 3; rs_d = 1; rt_d = 2; reg_write_d = 1;
        step();
        expect_now(mk("basic_load", 5, 7, 7, 3'b010, 3, 1, 0, 0, 1, 2, 1, 2'b00, 2'b00));

        clear_inputs();
        valid_d = 1; rs_d = 4; rt_d = 4; rd1_d = 32'h100; rd2_d = 32'h200;
        alu_control_d = 3'b000; mem_write_d = 1;
        reg_write_m = 1; write_reg_m = 4; alu_out_m = 32'h10;
        reg_write_w = 1; write_reg_w = 4; result_w = 32'h20;
        step();
        expect_now(mk("fwd_mem_wins", 32'h10, 32'h10, 32'h10, 3'b000, 4, 0, 0, 1, 4, 4, 1,
                      2'b10, 2'b10));
        reg_write_m = 0;
        expect_now(mk("fwd_wb", 32'h20, 32'h20, 32'h20, 3'b000, 4, 0, 0, 1, 4, 4, 1,
                      2'b01, 2'b01));

        clear_inputs();
        valid_d = 1; rs_d = 0; rt_d = 6; rd_d = 7; rd2_d = 32'h66; reg_dst_d = 1;
        alu_control_d = 3'b001;
        reg_write_m = 1; write_reg_m = 0; alu_out_m = 32'hFF;
        reg_write_w = 1; write_reg_w = 0; result_w = 32'hEE;
        step();
        expect_now(mk("r0_no_fwd", 0, 32'h66, 32'h66, 3'b001, 7, 0, 0, 0, 0, 6, 1,
                      2'b00, 2'b00));
        write_reg_w = 6;
        expect_now(mk("fwd_b_wb", 0, 32'hEE, 32'hEE, 3'b001, 7, 0, 0, 0, 0, 6, 1,
                      2'b00, 2'b01));

        clear_inputs();
        valid_d = 1; rs_d = 8; rt_d = 5; rd_d = 10; rd1_d = 32'h80; rd2_d = 32'h55;
        imm_d = 32'hFFFF_FFFC; alu_src_d = 1; reg_dst_d = 1; alu_control_d = 3'b111;
        reg_write_d = 1;
        reg_write_m = 1; write_reg_m = 5; alu_out_m = 32'h9;
        step();
        expect_now(mk("imm_store_fwd", 32'h80, 32'hFFFF_FFFC, 32'h9, 3'b111, 10, 1, 0, 0,
                      8, 5, 1, 2'b00, 2'b10));

        // Stall: decode inputs change but the held instruction must not.
        stall_e = 1; rd1_d = 32'hDEAD; rd2_d = 32'hBEEF; rs_d = 1; rt_d = 2; rd_d = 3;
        imm_d = 32'h1; alu_src_d = 0; alu_control_d = 3'b001; reg_write_d = 0;
        mem_write_d = 1; valid_d = 0;
        step();
        expect_now(mk("stall_1", 32'h80, 32'hFFFF_FFFC, 32'h9, 3'b111, 10, 1, 0, 0,
                      8, 5, 1, 2'b00, 2'b10));
        alu_out_m = 32'h99;
        step();
        expect_now(mk("stall_2_live_fwd", 32'h80, 32'hFFFF_FFFC, 32'h99, 3'b111, 10, 1, 0, 0,
                      8, 5, 1, 2'b00, 2'b10));
        reg_write_m = 0;
        step();
        expect_now(mk("stall_3_no_fwd", 32'h80, 32'hFFFF_FFFC, 32'h55, 3'b111, 10, 1, 0, 0,
                      8, 5, 1, 2'b00, 2'b00));

        flush_e = 1;
        step();
        expect_now(mk("stall_flush", 0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));

        load_reload();
        step();
        expect_now(mk("reload", 32'h11, 32'h22, 32'h22, 3'b110, 3, 1, 1, 0, 2, 3, 1,
                      2'b00, 2'b00));

        flush_e = 1;
        step();
        expect_now(mk("flush_only", 0, 0, 0, 3'b010, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));

        load_reload();
        step();
        expect_now(mk("reload_2", 32'h11, 32'h22, 32'h22, 3'b110, 3, 1, 1, 0, 2, 3, 1,
                      2'b00, 2'b00));

        rst = 1; stall_e = 1;
        step();
        expect_now(mk("reset_over_stall", 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0,
                      2'b00, 2'b00));

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #1;
        if (sb_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
